// File: rtl/ibex_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        MD_ITER_IDLE = 3'd0,
        MD_ITER_MUL  = 3'd1,
        MD_ITER_DIV  = 3'd2,
        MD_ITER_FIX  = 3'd3,
        MD_ITER_DONE = 3'd4
    } md_iter_state_e;

    typedef enum logic {
        MD_STEP_MUL = 1'b0,
        MD_STEP_DIV = 1'b1
    } md_step_mode_e;

    localparam int unsigned MdIterMaxWidth = 64;

    // Fixed (data-independent) latency from start acceptance to first valid cycle.
    function automatic int unsigned md_iter_latency(md_op_e op, int unsigned width,
                                                    int unsigned mul_bits);
        if (op == MD_OP_MULL || op == MD_OP_MULH) begin
            return width / mul_bits + 2;
        end
        return width + 2;
    endfunction

endpackage

// File: rtl/ibex_multdiv_iter_step.sv
// One iteration of the datapath: a MUL partial-product accumulate or a
// restoring-division trial subtraction, chosen by mode_i.
module ibex_multdiv_iter_step
    import ibex_pkg::*;
#(
    parameter int unsigned Width           = 32,
    parameter int unsigned MulBitsPerCycle = 2
) (
    input  md_step_mode_e                mode_i,
    input  logic [2*Width-1:0]           acc_i,
    input  logic [2*Width-1:0]           mcand_i,
    input  logic [MulBitsPerCycle-1:0]   digit_i,
    input  logic [Width-1:0]             rem_i,
    input  logic                         dvd_bit_i,
    input  logic [Width-1:0]             divisor_i,
    output logic [2*Width-1:0]           acc_o,
    output logic [Width-1:0]             rem_o,
    output logic                         qbit_o
);

    logic [2*Width-1:0] pp;
    logic [Width+1:0]   trial;

    // Shift-add partial product and Width+1-bit trial subtraction (extra MSB is the sign).
    always_comb begin
        pp = '0;
        for (int unsigned i = 0; i < MulBitsPerCycle; i++) begin
            if (digit_i[i]) begin
                pp = pp + (mcand_i << i);
            end
        end
        trial  = {1'b0, rem_i, dvd_bit_i} - {2'b00, divisor_i};
        acc_o  = acc_i;
        rem_o  = rem_i;
        qbit_o = 1'b0;
        if (mode_i == MD_STEP_MUL) begin
            acc_o = acc_i + pp;
        end else begin
            qbit_o = ~trial[Width+1];
            rem_o  = qbit_o ? trial[Width-1:0] : {rem_i[Width-2:0], dvd_bit_i};
        end
    end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit with valid/ready result handshake and kill.
module ibex_multdiv_iter
    import ibex_pkg::*;
#(
    parameter int unsigned Width           = 32,
    parameter int unsigned MulBitsPerCycle = 2,
    parameter bit          EarlyTerm       = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             ready_o,
    input  md_op_e           op_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             result_ready_i,
    output logic [Width-1:0] result_o,
    output logic             busy_o
);

    localparam int unsigned   NMul    = Width / MulBitsPerCycle;
    localparam int unsigned   CntW    = $clog2(MdIterMaxWidth + 1);
    localparam logic [CntW-1:0] MulLast = CntW'(NMul - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(Width - 1);

    md_iter_state_e     state_q, state_d;
    md_op_e             op_q, op_d;
    logic               sign_q, sign_d;
    logic               divz_q, divz_d;
    logic               et_q, et_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*Width-1:0] acc_q, acc_d;
    logic [2*Width-1:0] mcand_q, mcand_d;
    logic [Width-1:0]   opb_q, opb_d;
    logic [Width-1:0]   dvd_q, dvd_d;
    logic [Width-1:0]   rem_q, rem_d;
    logic [Width-1:0]   result_q, result_d;

    logic               neg_a, neg_b, start_mul, early_ok;
    logic [Width-1:0]   abs_a, abs_b;
    logic [2*Width-1:0] prod_fix;
    logic [2*Width-1:0] step_acc;
    logic [Width-1:0]   step_rem;
    logic               step_qbit;
    md_step_mode_e      step_mode;

    assign neg_a     = signed_mode_i[0] & op_a_i[Width-1];
    assign neg_b     = signed_mode_i[1] & op_b_i[Width-1];
    assign abs_a     = neg_a ? -op_a_i : op_a_i;
    assign abs_b     = neg_b ? -op_b_i : op_b_i;
    assign start_mul = (op_i == MD_OP_MULL) || (op_i == MD_OP_MULH);
    assign early_ok  = EarlyTerm && !data_ind_timing_i;
    assign prod_fix  = sign_q ? -acc_q : acc_q;
    assign step_mode = (state_q == MD_ITER_DIV) ? MD_STEP_DIV : MD_STEP_MUL;

    ibex_multdiv_iter_step #(
        .Width           (Width),
        .MulBitsPerCycle (MulBitsPerCycle)
    ) u_step (
        .mode_i    (step_mode),
        .acc_i     (acc_q),
        .mcand_i   (mcand_q),
        .digit_i   (opb_q[MulBitsPerCycle-1:0]),
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[Width-1]),
        .divisor_i (opb_q),
        .acc_o     (step_acc),
        .rem_o     (step_rem),
        .qbit_o    (step_qbit)
    );

    // Next-state and datapath update; kill overrides every transition last.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_d   = sign_q;
        divz_d   = divz_q;
        et_d     = et_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        result_d = result_q;
        unique case (state_q)
            MD_ITER_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    sign_d  = (op_i == MD_OP_REM) ? neg_a : (neg_a ^ neg_b);
                    divz_d  = (op_b_i == '0);
                    et_d    = early_ok;
                    cnt_d   = '0;
                    acc_d   = '0;
                    rem_d   = '0;
                    mcand_d = {{Width{1'b0}}, abs_a};
                    dvd_d   = abs_a;
                    opb_d   = abs_b;
                    if (start_mul) begin
                        state_d = MD_ITER_MUL;
                    end else if (early_ok && op_b_i == '0) begin
                        // Divide-by-zero shortcut: results are known without iterating.
                        state_d  = MD_ITER_DONE;
                        result_d = (op_i == MD_OP_DIV) ? '1 : op_a_i;
                    end else begin
                        state_d = MD_ITER_DIV;
                    end
                end
            end
            MD_ITER_MUL: begin
                acc_d   = step_acc;
                mcand_d = mcand_q << MulBitsPerCycle;
                opb_d   = opb_q >> MulBitsPerCycle;
                cnt_d   = cnt_q + CntW'(1);
                // Multiplicand shifts left instead of the product right, so
                // stopping early leaves the product already aligned.
                if (cnt_q == MulLast || (et_q && opb_q[Width-1:MulBitsPerCycle] == '0)) begin
                    state_d = MD_ITER_FIX;
                end
            end
            MD_ITER_DIV: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[Width-2:0], step_qbit};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == DivLast) begin
                    state_d = MD_ITER_FIX;
                end
            end
            MD_ITER_FIX: begin
                unique case (op_q)
                    MD_OP_MULL: result_d = prod_fix[Width-1:0];
                    MD_OP_MULH: result_d = prod_fix[2*Width-1:Width];
                    MD_OP_DIV:  result_d = divz_q ? '1 : (sign_q ? -dvd_q : dvd_q);
                    MD_OP_REM:  result_d = sign_q ? -rem_q : rem_q;
                endcase
                state_d = MD_ITER_DONE;
            end
            MD_ITER_DONE: begin
                if (result_ready_i) begin
                    state_d = MD_ITER_IDLE;
                end
            end
            default: state_d = MD_ITER_IDLE;
        endcase
        if (kill_i) begin
            state_d  = MD_ITER_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MD_ITER_IDLE;
            op_q     <= MD_OP_MULL;
            sign_q   <= 1'b0;
            divz_q   <= 1'b0;
            et_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            divz_q   <= divz_d;
            et_q     <= et_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == MD_ITER_IDLE);
    assign busy_o   = (state_q != MD_ITER_IDLE);
    assign valid_o  = (state_q == MD_ITER_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed and table-driven bench for the iterative multiply/divide unit
// (32-bit/2-bit-per-cycle and 64-bit/4-bit-per-cycle instances).
module tb_ibex_multdiv_iter;
    import ibex_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_start, s_dit, s_kill, s_rr, s_ready, s_valid, s_busy;
    md_op_e      s_op;
    logic [1:0]  s_mode;
    logic [31:0] s_a, s_b, s_res;

    logic        w_start, w_dit, w_kill, w_rr, w_ready, w_valid, w_busy;
    md_op_e      w_op;
    logic [1:0]  w_mode;
    logic [63:0] w_a, w_b, w_res;

    ibex_multdiv_iter #(.Width(32), .MulBitsPerCycle(2), .EarlyTerm(1'b1)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .ready_o(s_ready), .op_i(s_op),
        .signed_mode_i(s_mode), .op_a_i(s_a), .op_b_i(s_b), .data_ind_timing_i(s_dit),
        .kill_i(s_kill), .valid_o(s_valid), .result_ready_i(s_rr), .result_o(s_res),
        .busy_o(s_busy)
    );

    ibex_multdiv_iter #(.Width(64), .MulBitsPerCycle(4), .EarlyTerm(1'b1)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(w_start), .ready_o(w_ready), .op_i(w_op),
        .signed_mode_i(w_mode), .op_a_i(w_a), .op_b_i(w_b), .data_ind_timing_i(w_dit),
        .kill_i(w_kill), .valid_o(w_valid), .result_ready_i(w_rr), .result_o(w_res),
        .busy_o(w_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        md_op_e      op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic        dit;
        logic [31:0] exp;
        int          lat;
    } vec32_t;

    // Reference for the 64-bit sweep, built from native wide arithmetic.
    function automatic logic [63:0] ref64(md_op_e op, logic [1:0] m, logic [63:0] a, logic [63:0] b);
        logic signed [129:0] ea, eb, p;
        logic signed [63:0]  sa, sb;
        logic                sgn;
        ea  = m[0] ? {{66{a[63]}}, a} : {66'b0, a};
        eb  = m[1] ? {{66{b[63]}}, b} : {66'b0, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        sgn = (m == 2'b11);
        case (op)
            MD_OP_MULL: return p[63:0];
            MD_OP_MULH: return p[127:64];
            MD_OP_DIV: begin
                if (b == 64'd0) return '1;
                if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return a;
                if (sgn) return sa / sb;
                return a / b;
            end
            default: begin
                if (b == 64'd0) return a;
                if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                if (sgn) return sa % sb;
                return a % b;
            end
        endcase
    endfunction

    // Issue one op on the 32-bit unit; lat counts cycles from acceptance to first valid.
    task automatic run32(input md_op_e op, input logic [1:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic dit, output logic [31:0] res,
                         output int lat);
        @(negedge clk);
        s_op = op; s_mode = m; s_a = a; s_b = b; s_dit = dit; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        lat = 1;
        while (!s_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = s_res;
    endtask

    task automatic release32();
        @(negedge clk); s_rr = 1'b1;
        @(posedge clk); #1; s_rr = 1'b0;
    endtask

    task automatic run64(input md_op_e op, input logic [1:0] m, input logic [63:0] a,
                         input logic [63:0] b, input logic dit, output logic [63:0] res,
                         output int lat);
        @(negedge clk);
        w_op = op; w_mode = m; w_a = a; w_b = b; w_dit = dit; w_start = 1'b1;
        @(posedge clk); #1;
        w_start = 1'b0;
        lat = 1;
        while (!w_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = w_res;
        @(negedge clk); w_rr = 1'b1;
        @(posedge clk); #1; w_rr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec32_t      tv[$];
        logic [31:0] r32;
        logic [63:0] r64, exp64, a64, b64;
        md_op_e      op64;
        logic [1:0]  m64;
        int          lat;

        s_start = 0; s_dit = 0; s_kill = 0; s_rr = 0; s_op = MD_OP_MULL; s_mode = 0; s_a = 0; s_b = 0;
        w_start = 0; w_dit = 0; w_kill = 0; w_rr = 0; w_op = MD_OP_MULL; w_mode = 0; w_a = 0; w_b = 0;

        tv.push_back('{MD_OP_MULL, 2'b00, 32'h0001_2345, 32'h0000_0100, 1'b1, 32'h0123_4500, 18});
        tv.push_back('{MD_OP_MULH, 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 18});
        tv.push_back('{MD_OP_MULL, 2'b11, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFA, 18});
        tv.push_back('{MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 18});
        tv.push_back('{MD_OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 18});
        tv.push_back('{MD_OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 34});
        tv.push_back('{MD_OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 34});
        tv.push_back('{MD_OP_DIV,  2'b00, 32'h0000_1234, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1});
        tv.push_back('{MD_OP_REM,  2'b00, 32'h0000_1234, 32'h0000_0000, 1'b0, 32'h0000_1234, 1});
        tv.push_back('{MD_OP_DIV,  2'b00, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 34});
        tv.push_back('{MD_OP_REM,  2'b00, 32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_1234, 34});
        tv.push_back('{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFD, 34});
        tv.push_back('{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 34});
        tv.push_back('{MD_OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 34});
        tv.push_back('{MD_OP_REM,  2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 32'hFFFF_FFF9, 34});
        tv.push_back('{MD_OP_MULL, 2'b00, 32'h0000_0007, 32'h0000_0003, 1'b0, 32'h0000_0015, 3});
        tv.push_back('{MD_OP_DIV,  2'b00, 32'd1000,      32'd7,         1'b0, 32'd142,       34});

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ready32", {63'd0, s_ready}, 64'd1);
        check("reset valid32", {63'd0, s_valid}, 64'd0);
        check("reset busy32",  {63'd0, s_busy},  64'd0);
        check("reset result32", {32'd0, s_res},  64'd0);
        check("reset ready64", {63'd0, w_ready}, 64'd1);
        check("reset result64", w_res, 64'd0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            run32(tv[i].op, tv[i].mode, tv[i].a, tv[i].b, tv[i].dit, r32, lat);
            check($sformatf("vec%0d result", i), {32'd0, r32}, {32'd0, tv[i].exp});
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(tv[i].lat));
            release32();
        end

        // Back-pressure, with a start pulse while busy that must be ignored
        @(negedge clk);
        s_op = MD_OP_MULL; s_mode = 2'b00; s_a = 32'd5; s_b = 32'd9; s_dit = 1'b1; s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        @(negedge clk);
        s_op = MD_OP_DIV; s_a = 32'd100; s_b = 32'd100; s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        lat = 2;
        while (!s_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy start ignored latency", 64'(lat), 64'd18);
        check("busy start ignored result", {32'd0, s_res}, 64'd45);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("backpressure%0d", k), {s_valid, s_ready, s_res}, {1'b1, 1'b0, 32'd45});
        end
        release32();
        check("after release ready", {63'd0, s_ready}, 64'd1);

        // Kill in MUL cycle 7
        @(negedge clk);
        s_op = MD_OP_MULL; s_mode = 2'b00; s_a = 32'h1234_5678; s_b = 32'h8765_4321; s_dit = 1'b1; s_start = 1'b1;
        @(posedge clk); #1; s_start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("busy before kill", {63'd0, s_busy}, 64'd1);
        s_kill = 1'b1; s_rr = 1'b1;
        @(posedge clk); #1;
        s_kill = 1'b0; s_rr = 1'b0;
        check("after kill", {s_busy, s_valid, s_ready, s_res}, {1'b0, 1'b0, 1'b1, 32'd45});
        run32(MD_OP_MULL, 2'b00, 32'd6, 32'd7, 1'b0, r32, lat);
        check("post-kill result", {32'd0, r32}, 64'd42);
        check("post-kill latency", 64'(lat), 64'd4);

        // Kill in DONE drops valid next cycle and keeps the result
        @(negedge clk); s_kill = 1'b1;
        @(posedge clk); #1; s_kill = 1'b0;
        check("kill in done", {s_valid, s_ready, s_res}, {1'b0, 1'b1, 32'd42});

        // 64-bit, 4 bits per cycle
        run64(MD_OP_DIV, 2'b11, 64'h8000_0000_0000_0000, '1, 1'b1, r64, lat);
        check("w64 overflow div", r64, 64'h8000_0000_0000_0000);
        check("w64 overflow div latency", 64'(lat), 64'd66);
        run64(MD_OP_MULL, 2'b00, 64'hDEAD_BEEF_0BAD_F00D, 64'd1, 1'b0, r64, lat);
        check("w64 early mul result", r64, 64'hDEAD_BEEF_0BAD_F00D);
        n_checks++;
        if (lat > 3) begin
            n_fail++;
            $display("FAIL w64 early mul latency: got %0d required <= 3", lat);
        end
        for (int i = 0; i < 12; i++) begin
            op64 = md_op_e'(2'($urandom_range(0, 3)));
            if (op64 == MD_OP_MULL || op64 == MD_OP_MULH) m64 = 2'($urandom_range(0, 3));
            else m64 = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            a64 = {$urandom, $urandom};
            b64 = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom};
            exp64 = ref64(op64, m64, a64, b64);
            run64(op64, m64, a64, b64, 1'b1, r64, lat);
            check($sformatf("w64 rand%0d op%0d m%0d result", i, op64, m64), r64, exp64);
            check($sformatf("w64 rand%0d latency", i), 64'(lat), 64'(md_iter_latency(op64, 64, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_multdiv_iter.md
Name: ibex_multdiv_iter

Overview:
- Parametrised iterative RV32M/RV64M-style multiply/divide unit for the ibex execution stage.
- Generalises the existing multdiv in three ways: operand width, multiplier bits retired per cycle, and early termination.
- Adds a valid/ready result handshake and a kill input, so the ID stage can flush a busy operation and the result can be held under back-pressure.
- Owns all of its own datapath state; it does not borrow the ALU adder or the intermediate-value register.

Parameters:
- Width, 32: operand/result width; must be 32 or 64.
- MulBitsPerCycle, 2: multiplier bits retired per MUL iteration; must be 1, 2 or 4 and divide Width.
- EarlyTerm, 1: enables data-dependent early termination; when 0, latency is always fixed.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  operation request; accepted only when ready_o=1.
- ready_o  out  1  unit idle and can accept start_i.
- op_i  in  ibex_pkg::md_op_e  MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM.
- signed_mode_i  in  2  bit0: op_a signed; bit1: op_b signed.
- op_a_i  in  Width  multiplicand / dividend.
- op_b_i  in  Width  multiplier / divisor.
- data_ind_timing_i  in  1  1 forces fixed latency, overriding EarlyTerm.
- kill_i  in  1  abort the current operation.
- valid_o  out  1  result_o valid.
- result_ready_i  in  1  consumer takes the result.
- result_o  out  Width  registered result.
- busy_o  out  1  unit is in any non-IDLE state.

Behaviour:
- Reset: state IDLE; ready_o=1, valid_o=0, busy_o=0, result_o=0; all datapath registers cleared.
- FSM states: IDLE, MUL, DIV, FIX, DONE. The state typedef is md_iter_state_e.
- IDLE:
  - On start_i, latch |op_a| and |op_b| (absolute value only where the corresponding signed_mode bit is set and the operand is negative).
  - Latch the result sign: sa^sb for multiply; sa^sb for quotient; sa for remainder.
  - Clear the accumulator and the iteration counter.
  - Next state: MUL for MULL/MULH, DIV for DIV/REM.
- MUL:
  - Each cycle: accumulator += (|a| × next MulBitsPerCycle bits of |b|) shifted into a 2·Width product register; the multiplier is shifted right.
  - N_mul = Width/MulBitsPerCycle iterations, then FIX.
- DIV:
  - Restoring division, 1 quotient bit per cycle.
  - Trial subtraction is Width+1 bits wide; a non-negative difference sets the quotient bit and replaces the partial remainder.
  - N_div = Width iterations, then FIX.
- FIX (1 cycle):
  - Negate the selected result if its sign flag is set.
  - Selection: MULL gives product[Width-1:0]; MULH gives product[2W-1:W]; DIV gives the quotient; REM gives the remainder.
  - The result is written to result_o. Next state DONE.
- DONE:
  - valid_o=1; result_o stable.
  - Transitions to IDLE on result_ready_i.
  - start_i is not accepted in DONE (ready_o=0), which forces a one-cycle bubble.
- Latency, counted from the start_i acceptance edge to the first valid_o cycle: N_mul+2 or N_div+2.
  - Width=32, MulBitsPerCycle=2: MUL valid in cycle 18, DIV in cycle 34.
- Early termination (only when EarlyTerm=1 and data_ind_timing_i=0):
  - MUL: if the remaining multiplier bits are all zero at the start of a MUL cycle, go to FIX next cycle.
  - DIV by zero: IDLE goes directly to DONE with no FIX.
- Fixed results, independent of timing mode:
  - DIV by zero: quotient = all ones; remainder = op_a_i unmodified.
  - Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
  - In fixed-timing mode both cases still take the full N_div+2 latency.
- kill_i:
  - From any state, next state is IDLE; valid_o falls the following cycle.
  - kill_i has priority over start_i, over result_ready_i, and over FIX completion.
  - result_o keeps its last value.
- start_i while busy is ignored; no queueing.
- busy_o = (state != IDLE). ready_o = (state == IDLE).
- Reset mid-operation: asynchronous return to reset values in the same cycle.

Decomposition:
- ibex_pkg gains:
  - md_iter_state_e.
  - localparam MdIterMaxWidth = 64.
  - A function md_iter_latency(op, Width, MulBitsPerCycle) that returns the fixed latency, for use by the ID stall logic and SVA.
- One combinational sub-module, ibex_multdiv_iter_step:
  - One MUL partial-product add or one DIV trial subtraction, selected by a mode input.
  - Keeps the FSM file free of arithmetic.

Test Plan:
- Width=32, MulBitsPerCycle=2, MULL, unsigned: 0x0001_2345 × 0x0000_0100, data_ind_timing_i=1 -> valid_o in cycle 18, result_o=0x0123_4500.
- MULH signed (mode 2'b11): 0xFFFF_FFFE × 0x0000_0003 -> result_o=0xFFFF_FFFF. The same operands as MULL -> 0xFFFF_FFFA.
- DIV signed: 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000. REM with the same operands -> 0. Both valid in cycle 34.
- DIV/REM by zero, dividend 0x1234:
  - data_ind_timing_i=0: DIV returns 0xFFFF_FFFF and valid_o rises in cycle 1; REM returns 0x1234.
  - data_ind_timing_i=1: valid_o in cycle 34.
- Back-pressure and kill:
  - Hold result_ready_i=0 for 5 cycles -> valid_o and result_o stable, ready_o=0.
  - Assert kill_i in MUL cycle 7 -> next cycle state IDLE, valid_o=0, ready_o=1, and a new start is accepted.
- Width=64, MulBitsPerCycle=4: random signed/unsigned sweep against a reference model -> MUL valid in cycle 18, DIV in cycle 66; early-terminated MUL with op_b=1 is valid in cycle ≤3.
